// File: rtl/mips_cpu_bus_access.sv
// mips_cpu_bus_access: load/store bus-access unit between the MIPS core and an Avalon-MM master port
module mips_cpu_bus_access #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                busy,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 2);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic wr_q, sgn_q, err_q, bad, tmo;
  logic [1:0] size_q;
  logic [OW-1:0] off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0] be_q, bm;
  logic [DATA_W-1:0] wd_q, rdata_q, sh, rmask, ext;
  logic [CW-1:0] cnt;
  // A shift of the all-ones pattern past the width yields 0, so the full-width mask falls out naturally.
  function automatic logic [DATA_W-1:0] dmask(input logic [1:0] s);
    return ~({DATA_W{1'b1}} << (7'd8 << s));
  endfunction
  always_comb begin
    bad = (req_size == 2'd3 && DATA_W == 32) || |(req_addr[2:0] & ~(3'b111 << req_size));
    tmo = MAX_WAIT > 0 && waitrequest && cnt == CW'(MAX_WAIT - 1);
    bm = ~({NB{1'b1}} << (4'd1 << req_size));
    sh = readdata >> {off_q, 3'b000};
    rmask = dmask(size_q);
    ext = (sh & rmask) | ({DATA_W{sgn_q && |(sh & rmask & ~(rmask >> 1))}} & ~rmask);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (req_valid ? (bad ? DONE : BUS) : IDLE) :
              state == BUS  ? ((!waitrequest || tmo) ? DONE : BUS) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wd_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      wr_q <= req_write;
      sgn_q <= req_signed;
      size_q <= req_size;
      off_q <= req_addr[OW-1:0];
      addr_q <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
      be_q <= bm << req_addr[OW-1:0];
      wd_q <= (req_wdata & dmask(req_size)) << {req_addr[OW-1:0], 3'b000};
      err_q <= bad;
      rdata_q <= '0;
      cnt <= '0;
    end else if (state == BUS) begin
      cnt <= cnt + CW'(waitrequest);
      if (tmo) err_q <= 1'b1;
      else if (!waitrequest && !wr_q) rdata_q <= ext;
    end
  end
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    resp_valid = state == DONE;
    resp_err = resp_valid && err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    read = state == BUS && !wr_q;
    write = state == BUS && wr_q;
    address = addr_q;
    byteenable = be_q;
    writedata = wd_q;
  end
endmodule

// File: tb/tb_mips_cpu_bus_access.sv
// tb_mips_cpu_bus_access: scoreboard bench with directed and random loads/stores against a byte-lane model
module tb_mips_cpu_bus_access;
  localparam int MW = 4;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, req_signed = 0, waitrequest = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, readdata = 0;
  logic req_ready, resp_valid, resp_err, busy, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0] byteenable;
  int checks = 0, errors = 0;
  typedef struct {logic err; logic [31:0] rdata;} resp_t;
  resp_t exp_q[$];

  mips_cpu_bus_access #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
    if (read || write) chk("strobe_excl", read && write, 0);
  end

  task automatic run(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int nw);
    longint unsigned bytes, off, m, v;
    logic bad, tmo, done;
    int strobes, k, lat;
    resp_t e;
    logic [31:0] eb, ew;
    bytes = 64'd1 << sz;
    off = a % 4;
    bad = (sz == 2'd3) || (a % bytes != 0);
    tmo = !bad && nw >= MW;
    m = (64'd1 << (8 * bytes)) - 1;
    v = ({32'b0, rd} >> (8 * off)) & m;
    if (sg && v[8 * bytes - 1]) v = v | ~m;
    e.err = bad || tmo;
    e.rdata = (w || bad || tmo) ? 32'd0 : v[31:0];
    eb = 32'((64'd1 << bytes) - 1) << off;
    ew = (wd & m[31:0]) << (8 * off);
    strobes = bad ? 0 : tmo ? MW : nw + 1;
    exp_q.push_back(e);
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1;
    req_write = w;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    readdata = rd;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_write = 1'($urandom);
    req_size = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    k = 0;
    lat = 0;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (read || write) begin
        chk("address", address, a & ~32'd3);
        chk("byteenable", {28'd0, byteenable}, eb);
        chk("write", write, w);
        chk("read", read, !w);
        if (w) chk("writedata", writedata, ew);
        waitrequest = k < nw;
        k++;
      end
      if (resp_valid) begin
        done = 1;
        lat = c;
      end
    end
    waitrequest = 0;
    chk("resp_seen", done, 1);
    chk("strobe_cycles", k, strobes);
    chk("latency", lat, strobes + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_be", {28'd0, byteenable}, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    run(0, 2, 0, 32'h1000, 0, 32'hDEADBEEF, 0);
    run(0, 0, 1, 32'h1003, 0, 32'h80FF0000, 0);
    run(0, 0, 0, 32'h1003, 0, 32'h80FF0000, 0);
    run(0, 1, 0, 32'h1002, 0, 32'h80FF0000, 0);
    run(1, 1, 0, 32'h2002, 32'h1234ABCD, 32'h55555555, 3);
    run(0, 2, 0, 32'h1001, 0, 32'h11111111, 0);
    run(1, 1, 0, 32'h2003, 32'hCAFEF00D, 0, 0);
    run(0, 3, 0, 32'h3000, 0, 32'h22222222, 0);
    run(0, 2, 1, 32'h4000, 0, 32'h33333333, 50);
    // reset pulsed during the second wait cycle of a stalled load
    @(negedge clk);
    req_valid = 1;
    req_write = 0;
    req_size = 2;
    req_addr = 32'h1000;
    waitrequest = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_read_before", read, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_read", read, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    rst = 0;
    waitrequest = 0;
    run(0, 2, 0, 32'h1000, 0, 32'hA5A5A5A5, 0);
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      run(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 5));
    end
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
